// File: rtl/rca_config_table_pkg.sv
// Shared types and default geometry for the RCA port-mapping table and its
// operand sequencer.
package rca_config_table_pkg;

    localparam int unsigned NUM_RCAS        = 4;
    localparam int unsigned NUM_READ_PORTS  = 5;
    localparam int unsigned NUM_WRITE_PORTS = 5;
    localparam int unsigned REG_ADDR_W      = 5;

    localparam int unsigned RCA_ID_W   = $clog2(NUM_RCAS);
    localparam int unsigned MAX_PORTS  = (NUM_READ_PORTS > NUM_WRITE_PORTS) ?
                                         NUM_READ_PORTS : NUM_WRITE_PORTS;
    localparam int unsigned PORT_SEL_W = $clog2(MAX_PORTS);

    // One mapping: a port of an RCA bound to an architectural register.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
    } rca_port_entry_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_ISSUE,
        SEQ_DONE
    } seq_state_t;

endpackage

// File: rtl/rca_config_table_sequencer.sv
// Source-operand sequencer: on a use request it snapshots the mapped source
// ports of one RCA and streams them lowest port first, one beat per handshake.
module rca_operand_sequencer #(
    parameter  int unsigned NUM_RCAS       = rca_config_table_pkg::NUM_RCAS,
    parameter  int unsigned NUM_READ_PORTS = rca_config_table_pkg::NUM_READ_PORTS,
    parameter  int unsigned REG_ADDR_W     = rca_config_table_pkg::REG_ADDR_W,
    parameter  int unsigned PORT_SEL_W     = rca_config_table_pkg::PORT_SEL_W,
    localparam int unsigned RCA_ID_W       = $clog2(NUM_RCAS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 use_valid,
    input  logic [RCA_ID_W-1:0]                  use_rca,
    output logic                                 use_ready,
    output logic [RCA_ID_W-1:0]                  row_rca,
    input  logic [NUM_READ_PORTS-1:0]            row_valid,
    input  logic [NUM_READ_PORTS*REG_ADDR_W-1:0] row_addr,
    output logic                                 busy,
    output logic [RCA_ID_W-1:0]                  seq_rca,
    output logic                                 rd_valid,
    input  logic                                 rd_ready,
    output logic [PORT_SEL_W-1:0]                rd_port,
    output logic [REG_ADDR_W-1:0]                rd_addr,
    output logic                                 rd_last,
    output logic                                 seq_done
);
    import rca_config_table_pkg::*;

    seq_state_t                state;
    logic [NUM_READ_PORTS-1:0] mask;
    logic [NUM_READ_PORTS-1:0] next_mask;
    logic [PORT_SEL_W-1:0]     row_pick;
    logic [PORT_SEL_W-1:0]     next_pick;
    logic [REG_ADDR_W-1:0]     row_pick_addr;
    logic [REG_ADDR_W-1:0]     next_pick_addr;
    logic                      row_found;
    logic                      next_found;

    assign use_ready = (state == SEQ_IDLE);
    assign rd_valid  = (state == SEQ_ISSUE);
    assign seq_done  = (state == SEQ_DONE);
    assign busy      = (state != SEQ_IDLE);

    // Table row index, remaining-port mask and lowest-port priority picks.
    // The row follows use_rca while idle so the snapshot and first beat can
    // be captured on the accepting edge; afterwards it follows the latched RCA.
    always_comb begin
        row_rca        = (state == SEQ_IDLE) ? use_rca : seq_rca;
        next_mask      = mask;
        row_pick       = '0;
        next_pick      = '0;
        row_found      = 1'b0;
        next_found     = 1'b0;
        row_pick_addr  = '0;
        next_pick_addr = '0;
        for (int unsigned i = 0; i < NUM_READ_PORTS; i++) begin
            if (PORT_SEL_W'(i) == rd_port) next_mask[i] = 1'b0;
        end
        for (int unsigned i = 0; i < NUM_READ_PORTS; i++) begin
            if (row_valid[i] && !row_found) begin
                row_pick  = PORT_SEL_W'(i);
                row_found = 1'b1;
            end
            if (next_mask[i] && !next_found) begin
                next_pick  = PORT_SEL_W'(i);
                next_found = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_READ_PORTS; i++) begin
            if (PORT_SEL_W'(i) == row_pick)
                row_pick_addr = row_addr[i*REG_ADDR_W +: REG_ADDR_W];
            if (PORT_SEL_W'(i) == next_pick)
                next_pick_addr = row_addr[i*REG_ADDR_W +: REG_ADDR_W];
        end
    end

    // Sequencer FSM; the beat outputs are registered one step ahead so each
    // beat is presented the cycle after the accept or the previous handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SEQ_IDLE;
            mask    <= '0;
            seq_rca <= '0;
            rd_port <= '0;
            rd_addr <= '0;
            rd_last <= 1'b0;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    if (use_valid) begin
                        seq_rca <= use_rca;
                        mask    <= row_valid;
                        rd_port <= row_pick;
                        rd_addr <= row_pick_addr;
                        rd_last <= $onehot(row_valid);
                        state   <= (row_valid != '0) ? SEQ_ISSUE : SEQ_DONE;
                    end
                end
                SEQ_ISSUE: begin
                    if (rd_ready) begin
                        mask <= next_mask;
                        if (rd_last) begin
                            rd_last <= 1'b0;
                            state   <= SEQ_DONE;
                        end else begin
                            rd_port <= next_pick;
                            rd_addr <= next_pick_addr;
                            rd_last <= $onehot(next_mask);
                        end
                    end
                end
                SEQ_DONE: begin
                    state <= SEQ_IDLE;
                end
                default: begin
                    state <= SEQ_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/rca_config_table.sv
// Per-RCA source/destination port-mapping tables with config decode, the
// operand sequencer for use instructions, and the writeback lookup.
module rca_config_table #(
    parameter  int unsigned NUM_RCAS        = rca_config_table_pkg::NUM_RCAS,
    parameter  int unsigned NUM_READ_PORTS  = rca_config_table_pkg::NUM_READ_PORTS,
    parameter  int unsigned NUM_WRITE_PORTS = rca_config_table_pkg::NUM_WRITE_PORTS,
    parameter  int unsigned REG_ADDR_W      = rca_config_table_pkg::REG_ADDR_W,
    parameter  int unsigned PORT_SEL_W      = rca_config_table_pkg::PORT_SEL_W,
    localparam int unsigned RCA_ID_W        = $clog2(NUM_RCAS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [RCA_ID_W-1:0]   cfg_rca,
    input  logic [PORT_SEL_W-1:0] cfg_port,
    input  logic                  cfg_is_dst,
    input  logic [REG_ADDR_W-1:0] cfg_reg,
    input  logic                  cfg_clear,
    output logic                  cfg_err,
    input  logic                  use_valid,
    output logic                  use_ready,
    input  logic [RCA_ID_W-1:0]   use_rca,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [PORT_SEL_W-1:0] rd_port,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic                  rd_last,
    output logic                  seq_done,
    input  logic [RCA_ID_W-1:0]   wb_rca,
    input  logic [PORT_SEL_W-1:0] wb_port,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic                  wb_hit
);
    import rca_config_table_pkg::*;

    // Table entries use the shared entry type, whose address field is fixed
    // by the package.
    if (REG_ADDR_W != rca_config_table_pkg::REG_ADDR_W) begin : g_entry_width_check
        $error("REG_ADDR_W must match rca_config_table_pkg::REG_ADDR_W");
    end

    rca_port_entry_t src_tbl [NUM_RCAS][NUM_READ_PORTS];
    rca_port_entry_t dst_tbl [NUM_RCAS][NUM_WRITE_PORTS];

    logic                                 cfg_fire;
    logic                                 port_ok;
    logic                                 busy;
    logic [RCA_ID_W-1:0]                  seq_rca;
    logic [RCA_ID_W-1:0]                  row_rca;
    logic [NUM_READ_PORTS-1:0]            row_valid;
    logic [NUM_READ_PORTS*REG_ADDR_W-1:0] row_addr;

    // Config handshake: block the RCA owned by a running sequence, and give a
    // same-cycle use request priority over a config to the same RCA.
    always_comb begin
        if (busy) cfg_ready = (seq_rca != cfg_rca);
        else      cfg_ready = !(use_valid && (use_rca == cfg_rca));
        port_ok  = cfg_is_dst ? (32'(cfg_port) < NUM_WRITE_PORTS)
                              : (32'(cfg_port) < NUM_READ_PORTS);
        cfg_fire = cfg_valid && cfg_ready;
    end

    // Table writes and per-RCA clears; out-of-range ports leave tables untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_RCAS; r++) begin
                for (int unsigned p = 0; p < NUM_READ_PORTS; p++)  src_tbl[r][p] <= '0;
                for (int unsigned p = 0; p < NUM_WRITE_PORTS; p++) dst_tbl[r][p] <= '0;
            end
        end else if (cfg_fire) begin
            for (int unsigned r = 0; r < NUM_RCAS; r++) begin
                if (RCA_ID_W'(r) == cfg_rca) begin
                    if (cfg_clear) begin
                        for (int unsigned p = 0; p < NUM_READ_PORTS; p++)  src_tbl[r][p].valid <= 1'b0;
                        for (int unsigned p = 0; p < NUM_WRITE_PORTS; p++) dst_tbl[r][p].valid <= 1'b0;
                    end else if (cfg_is_dst) begin
                        for (int unsigned p = 0; p < NUM_WRITE_PORTS; p++)
                            if (PORT_SEL_W'(p) == cfg_port)
                                dst_tbl[r][p] <= '{valid: 1'b1, addr: cfg_reg};
                    end else begin
                        for (int unsigned p = 0; p < NUM_READ_PORTS; p++)
                            if (PORT_SEL_W'(p) == cfg_port)
                                src_tbl[r][p] <= '{valid: 1'b1, addr: cfg_reg};
                    end
                end
            end
        end
    end

    // One-cycle error pulse for an accepted non-clear request with a bad port.
    always_ff @(posedge clk) begin
        if (rst) cfg_err <= 1'b0;
        else     cfg_err <= cfg_fire && !cfg_clear && !port_ok;
    end

    // Source row presented to the sequencer.
    always_comb begin
        row_valid = '0;
        row_addr  = '0;
        for (int unsigned r = 0; r < NUM_RCAS; r++) begin
            if (RCA_ID_W'(r) == row_rca) begin
                for (int unsigned p = 0; p < NUM_READ_PORTS; p++) begin
                    row_valid[p]                         = src_tbl[r][p].valid;
                    row_addr[p*REG_ADDR_W +: REG_ADDR_W] = src_tbl[r][p].addr;
                end
            end
        end
    end

    // Writeback destination lookup; ports past NUM_WRITE_PORTS never hit.
    always_comb begin
        wb_hit  = 1'b0;
        wb_addr = '0;
        for (int unsigned r = 0; r < NUM_RCAS; r++) begin
            if (RCA_ID_W'(r) == wb_rca) begin
                for (int unsigned p = 0; p < NUM_WRITE_PORTS; p++) begin
                    if (PORT_SEL_W'(p) == wb_port) begin
                        wb_hit  = dst_tbl[r][p].valid;
                        wb_addr = dst_tbl[r][p].addr;
                    end
                end
            end
        end
    end

    rca_operand_sequencer #(
        .NUM_RCAS       (NUM_RCAS),
        .NUM_READ_PORTS (NUM_READ_PORTS),
        .REG_ADDR_W     (REG_ADDR_W),
        .PORT_SEL_W     (PORT_SEL_W)
    ) u_seq (
        .clk       (clk),
        .rst       (rst),
        .use_valid (use_valid),
        .use_rca   (use_rca),
        .use_ready (use_ready),
        .row_rca   (row_rca),
        .row_valid (row_valid),
        .row_addr  (row_addr),
        .busy      (busy),
        .seq_rca   (seq_rca),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_port   (rd_port),
        .rd_addr   (rd_addr),
        .rd_last   (rd_last),
        .seq_done  (seq_done)
    );

endmodule

// File: tb/tb_rca_config_table.sv
// Directed bench for rca_config_table: config, sequencing, stalls, tie
// priority, bad ports, writeback lookup, clear and mid-sequence reset.
module tb_rca_config_table;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid, cfg_ready;
    logic [1:0] cfg_rca;
    logic [2:0] cfg_port;
    logic       cfg_is_dst;
    logic [4:0] cfg_reg;
    logic       cfg_clear, cfg_err;
    logic       use_valid, use_ready;
    logic [1:0] use_rca;
    logic       rd_valid, rd_ready;
    logic [2:0] rd_port;
    logic [4:0] rd_addr;
    logic       rd_last, seq_done;
    logic [1:0] wb_rca;
    logic [2:0] wb_port;
    logic [4:0] wb_addr;
    logic       wb_hit;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    rca_config_table #(
        .NUM_RCAS        (4),
        .NUM_READ_PORTS  (5),
        .NUM_WRITE_PORTS (5),
        .REG_ADDR_W      (5),
        .PORT_SEL_W      (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_rca    (cfg_rca),
        .cfg_port   (cfg_port),
        .cfg_is_dst (cfg_is_dst),
        .cfg_reg    (cfg_reg),
        .cfg_clear  (cfg_clear),
        .cfg_err    (cfg_err),
        .use_valid  (use_valid),
        .use_ready  (use_ready),
        .use_rca    (use_rca),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_port    (rd_port),
        .rd_addr    (rd_addr),
        .rd_last    (rd_last),
        .seq_done   (seq_done),
        .wb_rca     (wb_rca),
        .wb_port    (wb_port),
        .wb_addr    (wb_addr),
        .wb_hit     (wb_hit)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input int port, input int addr, input int last);
        check({tag, "_valid"}, rd_valid, 1);
        check({tag, "_port"},  rd_port,  port);
        check({tag, "_addr"},  rd_addr,  addr);
        check({tag, "_last"},  rd_last,  last);
    endtask

    task automatic check_done(input string tag);
        check({tag, "_rd_valid"},  rd_valid,  0);
        check({tag, "_seq_done"},  seq_done,  1);
        check({tag, "_use_ready"}, use_ready, 0);
    endtask

    task automatic do_cfg(input string tag, input int rca, input int port, input int is_dst,
                          input int rg, input int clr, input int exp_err);
        cfg_rca    = 2'(rca);
        cfg_port   = 3'(port);
        cfg_is_dst = is_dst[0];
        cfg_reg    = 5'(rg);
        cfg_clear  = clr[0];
        cfg_valid  = 1'b1;
        #1;
        check({tag, "_cfg_ready"}, cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        cfg_clear = 1'b0;
        check({tag, "_cfg_err"}, cfg_err, exp_err);
    endtask

    task automatic start_use(input string tag, input int rca);
        use_rca   = 2'(rca);
        use_valid = 1'b1;
        #1;
        check({tag, "_use_ready"}, use_ready, 1);
        tick();
        use_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        cfg_valid = 1'b0; cfg_rca = '0; cfg_port = '0; cfg_is_dst = 1'b0;
        cfg_reg = '0; cfg_clear = 1'b0;
        use_valid = 1'b0; use_rca = '0; rd_ready = 1'b1;
        wb_rca = '0; wb_port = '0;
        tick();
        tick();

        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_use_ready", use_ready, 1);
        check("rst_rd_valid",  rd_valid,  0);
        check("rst_rd_last",   rd_last,   0);
        check("rst_seq_done",  seq_done,  0);
        check("rst_cfg_err",   cfg_err,   0);
        check("rst_wb_hit",    wb_hit,    0);
        rst = 1'b0;
        tick();

        // Three mapped source ports on RCA2, streamed lowest port first.
        do_cfg("t1_c0", 2, 0, 0, 5, 0, 0);
        do_cfg("t1_c3", 2, 3, 0, 9, 0, 0);
        do_cfg("t1_c4", 2, 4, 0, 31, 0, 0);
        start_use("t1", 2);
        check_beat("t1_b0", 0, 5, 0);
        tick();
        check_beat("t1_b1", 3, 9, 0);
        tick();
        check_beat("t1_b2", 4, 31, 1);
        tick();
        check_done("t1_done");
        tick();
        check("t1_idle_seq_done",  seq_done,  0);
        check("t1_idle_use_ready", use_ready, 1);

        // Empty mask: done immediately, no beats.
        start_use("t2", 1);
        check_done("t2_done");
        tick();
        check("t2_idle_seq_done",  seq_done,  0);
        check("t2_idle_use_ready", use_ready, 1);

        // Stalled beat on RCA0; config to RCA0 blocked, RCA3 allowed.
        do_cfg("t3_c1", 0, 1, 0, 7, 0, 0);
        do_cfg("t3_c2", 0, 2, 0, 8, 0, 0);
        rd_ready = 1'b0;
        start_use("t3", 0);
        check_beat("t3_stall0", 1, 7, 0);
        cfg_rca = 2'd0; cfg_port = 3'd0; cfg_is_dst = 1'b0; cfg_reg = 5'd1; cfg_valid = 1'b1;
        #1;
        check("t3_cfg_same_rca_ready", cfg_ready, 0);
        cfg_rca = 2'd3; cfg_reg = 5'd20;
        #1;
        check("t3_cfg_other_rca_ready", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        check("t3_cfg_other_err", cfg_err, 0);
        check_beat("t3_stall1", 1, 7, 0);
        tick();
        check_beat("t3_stall2", 1, 7, 0);
        rd_ready = 1'b1;
        tick();
        check_beat("t3_b1", 2, 8, 1);
        tick();
        check_done("t3_done");
        tick();

        // Same-cycle tie in IDLE on RCA1: use wins, config waits for IDLE.
        use_rca = 2'd1; use_valid = 1'b1;
        cfg_rca = 2'd1; cfg_port = 3'd0; cfg_is_dst = 1'b0; cfg_reg = 5'd3; cfg_valid = 1'b1;
        #1;
        check("t4_tie_cfg_ready", cfg_ready, 0);
        check("t4_tie_use_ready", use_ready, 1);
        tick();
        use_valid = 1'b0;
        #1;
        check("t4_done_seq_done",  seq_done,  1);
        check("t4_done_cfg_ready", cfg_ready, 0);
        tick();
        check("t4_idle_cfg_ready", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        check("t4_cfg_err", cfg_err, 0);

        // Out-of-range ports, destination lookup, rewrite and clear.
        do_cfg("t5_bad_src", 0, 6, 0, 1, 0, 1);
        tick();
        check("t5_err_pulse_end", cfg_err, 0);
        do_cfg("t5_bad_dst", 3, 5, 1, 1, 0, 1);
        wb_rca = 2'd3; wb_port = 3'd5;
        #1;
        check("t5_wb_port5_hit", wb_hit, 0);
        wb_port = 3'd2;
        #1;
        check("t5_wb_empty_hit", wb_hit, 0);
        do_cfg("t5_dst2", 3, 2, 1, 12, 0, 0);
        #1;
        check("t5_wb_hit",  wb_hit,  1);
        check("t5_wb_addr", wb_addr, 12);
        do_cfg("t5_dst2_rw", 3, 2, 1, 13, 0, 0);
        #1;
        check("t5_wb_addr_rw", wb_addr, 13);
        start_use("t5_rca3", 3);
        check_beat("t5_rca3_b0", 0, 20, 1);
        tick();
        check_done("t5_rca3_done");
        tick();
        do_cfg("t5_clear", 3, 7, 0, 0, 1, 0);
        #1;
        check("t5_clear_wb_hit", wb_hit, 0);
        start_use("t5_rca3_clr", 3);
        check_done("t5_rca3_clr_done");
        tick();

        // Reset during beat 2 of 3 on RCA2.
        start_use("t6", 2);
        check_beat("t6_b0", 0, 5, 0);
        tick();
        check_beat("t6_b1", 3, 9, 0);
        rst = 1'b1;
        tick();
        check("t6_rst_rd_valid",  rd_valid,  0);
        check("t6_rst_rd_last",   rd_last,   0);
        check("t6_rst_seq_done",  seq_done,  0);
        check("t6_rst_use_ready", use_ready, 1);
        check("t6_rst_cfg_ready", cfg_ready, 1);
        rst = 1'b0;
        tick();
        check("t6_post_seq_done", seq_done, 0);
        start_use("t6_empty", 2);
        check_done("t6_empty_done");
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rca_config_table.md
# rca_config_table

Per-RCA port-mapping table and source-operand sequencer for the reconfigurable custom accelerator (RCA) path. Config instructions write, per RCA and per port, the architectural register that port accesses. Use instructions launch a sequencer that streams the configured source registers, one per beat, toward the register-file read stage. Writeback uses a combinational lookup of the destination mapping.

## Interface
Parameters:
- NUM_RCAS, 4, number of accelerators (funct7 selects one)
- NUM_READ_PORTS, 5, source ports per RCA
- NUM_WRITE_PORTS, 5, destination ports per RCA
- REG_ADDR_W, 5, register address width
- PORT_SEL_W, 3, port index width (rs1[2:0]); must satisfy 2**PORT_SEL_W >= max(NUM_READ_PORTS, NUM_WRITE_PORTS)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_valid / cfg_ready  in/out  1  config request handshake
- cfg_rca  in  $clog2(NUM_RCAS)  target RCA (funct7)
- cfg_port  in  PORT_SEL_W  port index (rs1[2:0])
- cfg_is_dst  in  1  0 = source port, 1 = destination port (rs1[3])
- cfg_reg  in  REG_ADDR_W  mapped register (rs2[4:0])
- cfg_clear  in  1  invalidate every mapping of cfg_rca; cfg_port and cfg_reg are ignored
- cfg_err  out  1  one-cycle pulse: the accepted request had an out-of-range port
- use_valid / use_ready  in/out  1  use request handshake
- use_rca  in  $clog2(NUM_RCAS)  RCA to run
- rd_valid / rd_ready  out/in  1  operand beat handshake
- rd_port  out  PORT_SEL_W  source port of the beat
- rd_addr  out  REG_ADDR_W  mapped register of the beat
- rd_last  out  1  final beat of the sequence
- seq_done  out  1  one-cycle pulse: the sequence finished
- wb_rca  in  $clog2(NUM_RCAS)  writeback lookup RCA
- wb_port  in  PORT_SEL_W  writeback lookup port
- wb_addr  out  REG_ADDR_W  mapped destination register (combinational)
- wb_hit  out  1  mapping is valid and wb_port < NUM_WRITE_PORTS (combinational)

## Operation
- Storage: src table NUM_RCAS x NUM_READ_PORTS and dst table NUM_RCAS x NUM_WRITE_PORTS. Each entry is {valid, addr}.
- Config accept (cfg_valid & cfg_ready):
  - Writes {1, cfg_reg} into the selected entry; visible the next cycle.
  - cfg_clear zeroes every valid bit of that RCA in both tables.
  - If the port is >= NUM_READ_PORTS (src) or >= NUM_WRITE_PORTS (dst), nothing is written and cfg_err pulses the next cycle.
  - A rewrite of a valid entry overwrites the address.
- cfg_ready = 0 when either holds; otherwise 1:
  - state != IDLE and seq_rca == cfg_rca;
  - state == IDLE and use_valid and use_rca == cfg_rca (use wins the tie).
- FSM IDLE -> ISSUE -> DONE -> IDLE:
  - IDLE: use_ready = 1. On accept, latch seq_rca and snapshot the src valid bits into mask. Go to ISSUE if mask != 0, else DONE.
  - ISSUE: rd_valid = 1. rd_port is the lowest set bit of mask; rd_addr is that entry's address; rd_last = (exactly one bit set). On rd_ready, clear that bit; after the last beat go to DONE. Outputs hold stable while rd_ready = 0.
  - DONE: seq_done = 1 for one cycle, use_ready = 0, then IDLE.
- use_ready is 0 in ISSUE and DONE.

## Timing
- Reset values: state IDLE; all valid bits 0; cfg_ready 1; use_ready 1; rd_valid 0; rd_last 0; seq_done 0; cfg_err 0; wb_hit 0.
- Use accepted at cycle T:
  - First rd_valid at T+1.
  - With k mapped ports and rd_ready held high, beats occur at T+1..T+k and seq_done at T+k+1.
  - For an empty mask, seq_done is at T+1.
- Back-to-back: the next use can be accepted at the cycle after seq_done.
- Config to another RCA proceeds during a sequence; the in-flight mask is a snapshot and is unaffected.
- rst mid-sequence: outputs take reset values at that edge and the tables clear. No seq_done is produced.

## Structure
- Extend the shared rca_config package with:
  - rca_port_entry_t {valid, addr};
  - a seq_state_t enum;
  - derived widths RCA_ID_W and PORT_SEL_W.
- One sub-module, rca_operand_sequencer: the FSM, mask, and priority pick. It reads the src table row via a combinational index.
- The tables and config decode stay in rca_config_table.

## Test plan
- Config src RCA2 ports 0,3,4 -> x5,x9,x31; use RCA2 with rd_ready = 1 -> beats (0,5),(3,9),(4,31,last) at T+1..T+3; seq_done at T+4.
- Use RCA1 with no mappings -> no rd_valid; seq_done at T+1; use_ready back at T+2.
- RCA0 two-beat sequence with rd_ready low 3 cycles on beat 1 -> rd_port/rd_addr stable; cfg to RCA0 stalled (cfg_ready = 0); cfg to RCA3 accepted.
- Same cycle in IDLE, use_rca = cfg_rca = 1 -> use accepted, cfg_ready = 0 until IDLE.
- cfg_port = 6 src, then cfg_port = 5 dst -> cfg_err pulses each time, no table change. Dst RCA3 port 2 -> x12 then wb_rca = 3, wb_port = 2 -> wb_hit = 1, wb_addr = 12. After cfg_clear RCA3 -> wb_hit = 0.
- rst asserted during beat 2 of 3 -> rd_valid = 0 next cycle, no seq_done. A following use shows an empty mask.
